processor_mem_arbiter: RTL

Shares the single-port synchronous data memory between the processor's last pipeline stage (loads/stores) and a host/debug port. It also sequences the processor's wait/continue handshake. While the processor is halted on a wait instruction, the host owns the memory exclusively; a host continue request releases the processor. The block sits between the final processor stage, the data RAM and the host bridge.

---
 rtl/processor_mem_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/processor_mem_arbiter.sv
// processor_mem_arbiter: shares the data RAM between CPU and host and sequences wait/continue
module processor_mem_arbiter #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_SIZE-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_grant,
  output logic                 cpu_stall,
  output logic                 cpu_rvalid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 cpu_waiting,
  output logic                 continue_out,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_grant,
  output logic                 host_rvalid,
  output logic [WORD_SIZE-1:0] host_rdata,
  input  logic                 host_continue,
  output logic                 halted,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {RUN, HALT, RESUME} state_t;
  state_t state;
  logic [SW-1:0] starve_cnt;
  logic host_wins;
  // host wins when halted, when uncontended, or when the CPU has starved it long enough
  always_comb begin
    host_wins = host_req & ((state == HALT) | ~cpu_req | (starve_cnt == SW'(STARVE_LIMIT)));
    host_grant = reset & host_wins;
    cpu_grant = reset & cpu_req & (state != HALT) & ~host_wins;
    cpu_stall = cpu_req & ~cpu_grant;
    mem_addr = host_grant ? host_addr : cpu_addr;
    mem_wdata = host_grant ? host_wdata : cpu_wdata;
    mem_we = (cpu_grant & cpu_we) | (host_grant & host_we);
  end
  assign cpu_rdata = mem_rdata;
  assign host_rdata = mem_rdata;
  // run/halt/resume sequencing, fairness counter and registered read-valid strobes
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      host_rvalid <= 1'b0;
      continue_out <= 1'b0;
      halted <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_grant & ~cpu_we;
      host_rvalid <= host_grant & ~host_we;
      starve_cnt <= (cpu_grant & host_req) ? starve_cnt + 1'b1 : '0;
      continue_out <= (state == HALT) & host_continue;
      halted <= ((state == RUN) & cpu_waiting) | ((state == HALT) & ~host_continue);
      state <= (state == RUN) ? (cpu_waiting ? HALT : RUN) :
               (state == HALT) ? (host_continue ? RESUME : HALT) : RUN;
    end
endmodule
